// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection phase sequencer.
//   phase_t   - state codes, also driven out on the phase port
//   LAMP_*    - lamp vectors, bit order {MR,MY,MG,SR,SY,SG}
//   lamps_of  - phase code to lamp vector; unknown codes show all-red
package traffic_pkg;

  typedef enum logic [2:0] {
    PH_INIT_RED    = 3'd0,
    PH_MAIN_GREEN  = 3'd1,
    PH_MAIN_YELLOW = 3'd2,
    PH_CLEAR_1     = 3'd3,
    PH_SIDE_GREEN  = 3'd4,
    PH_SIDE_YELLOW = 3'd5,
    PH_CLEAR_2     = 3'd6
  } phase_t;

  localparam logic [5:0] LAMP_RR = 6'b100_100;
  localparam logic [5:0] LAMP_GR = 6'b001_100;
  localparam logic [5:0] LAMP_YR = 6'b010_100;
  localparam logic [5:0] LAMP_RG = 6'b100_001;
  localparam logic [5:0] LAMP_RY = 6'b100_010;

  function automatic logic [5:0] lamps_of(input logic [2:0] p);
    case (p)
      PH_MAIN_GREEN:  lamps_of = LAMP_GR;
      PH_MAIN_YELLOW: lamps_of = LAMP_YR;
      PH_SIDE_GREEN:  lamps_of = LAMP_RG;
      PH_SIDE_YELLOW: lamps_of = LAMP_RY;
      default:        lamps_of = LAMP_RR;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_dwell_timer.sv
// dwell_timer: per-state dwell counter.
//   clk, rst     - clock, synchronous active-low reset
//   clr          - zero the counter (state entry); wins over tick
//   tick         - timebase strobe, counter advances only on tick (saturating)
//   dwell        - dwell length D in ticks, 1..2^CNT_W
//   expire       - tick && cnt == D-1
//   min_elapsed  - cnt >= D-1 (independent of tick)
module dwell_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W:0]   dwell,
  output logic             expire,
  output logic             min_elapsed
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   last;
  logic [CNT_W:0]   cnt_x;

  // D-1 always fits in CNT_W bits since D <= 2^CNT_W
  assign last        = dwell - 1'b1;
  assign cnt_x       = {1'b0, cnt};
  assign min_elapsed = (cnt_x >= last);
  assign expire      = tick && (cnt_x == last);

  always_ff @(posedge clk) begin
    if (!rst)                    cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (tick && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: timed, demand-driven main/side road light sequencer.
//   clk       - clock, rising edge
//   rst       - synchronous reset, active low
//   tick      - timebase strobe; dwell timing and state advance only on tick
//   side_req  - side-road sensor level, latched into demand
//   ped_req   - pedestrian button pulse (only with PED_WALK_EN)
//   MR..SG    - registered lamp outputs
//   walk      - pedestrian walk lamp, on during side green (only with PED_WALK_EN)
//   phase     - current state code
// Build option: define PED_WALK_EN to add the ped_req/walk ports.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic [2:0] phase
);

  localparam int DW = CNT_W + 1;

  localparam logic [2:0] S_INIT = PH_INIT_RED;
  localparam logic [2:0] S_MG   = PH_MAIN_GREEN;
  localparam logic [2:0] S_MY   = PH_MAIN_YELLOW;
  localparam logic [2:0] S_C1   = PH_CLEAR_1;
  localparam logic [2:0] S_SG   = PH_SIDE_GREEN;
  localparam logic [2:0] S_SY   = PH_SIDE_YELLOW;
  localparam logic [2:0] S_C2   = PH_CLEAR_2;

  logic [2:0]    state, nxt;
  logic          demand, req;
  logic [DW-1:0] dwell;
  logic          expire, min_elapsed;

`ifdef PED_WALK_EN
  assign req = side_req | ped_req;
`else
  assign req = side_req;
`endif

  // In MAIN_GREEN the dwell is the minimum green; leaving also needs demand.
  always_comb begin
    dwell = DW'(ALL_RED);
    case (state)
      S_MG:       dwell = DW'(MIN_GREEN);
      S_MY, S_SY: dwell = DW'(YELLOW);
      S_SG:       dwell = DW'(SIDE_GREEN);
      default:    dwell = DW'(ALL_RED);
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      S_INIT:  if (expire) nxt = S_MG;
      S_MG:    if (tick && demand && min_elapsed) nxt = S_MY;
      S_MY:    if (expire) nxt = S_C1;
      S_C1:    if (expire) nxt = S_SG;
      S_SG:    if (expire) nxt = S_SY;
      S_SY:    if (expire) nxt = S_C2;
      S_C2:    if (expire) nxt = S_MG;
      default: nxt = S_INIT;   // code 7 recovers in one cycle
    endcase
  end

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (nxt != state),
    .tick        (tick),
    .dwell       (dwell),
    .expire      (expire),
    .min_elapsed (min_elapsed)
  );

  // Lamps decode the next state so they switch on the same edge as state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= S_INIT;
      demand                 <= 1'b0;
      {MR, MY, MG, SR, SY, SG} <= LAMP_RR;
    end else begin
      state                  <= nxt;
      {MR, MY, MG, SR, SY, SG} <= lamps_of(nxt);
      // Entry into side green clears demand, overriding any request that cycle.
      if (nxt == S_SG && state != S_SG) demand <= 1'b0;
      else if (req && state != S_SG)    demand <= 1'b1;
    end
  end

`ifdef PED_WALK_EN
  always_ff @(posedge clk) begin
    if (!rst) walk <= 1'b0;
    else      walk <= (nxt == S_SG);
  end
`endif

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
module tb_traffic_phase_sequencer;

  logic clk = 1'b0;
  logic rst, tick, side_req;
  logic MR, MY, MG, SR, SY, SG;
  logic [2:0] phase;
`ifdef PED_WALK_EN
  logic ped_req, walk;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .MIN_GREEN(4), .SIDE_GREEN(3), .YELLOW(2), .ALL_RED(1), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .side_req(side_req),
`ifdef PED_WALK_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .MR(MR), .MY(MY), .MG(MG), .SR(SR), .SY(SY), .SG(SG), .phase(phase)
  );

  // Expected lamps {MR,MY,MG,SR,SY,SG} for a phase code
  function automatic logic [5:0] exp_lamps(input logic [2:0] p);
    case (p)
      3'd1:    return 6'b001100;
      3'd2:    return 6'b010100;
      3'd4:    return 6'b100001;
      3'd5:    return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  task automatic step(input logic r, input logic t, input logic s, input logic p,
                      input logic [2:0] ep, input string nm);
    logic [5:0] lamps;
    logic ok;
    rst = r; tick = t; side_req = s;
`ifdef PED_WALK_EN
    ped_req = p;
`else
    if (p) $display("note: ped_req stimulus dropped in %s", nm);
`endif
    @(posedge clk);
    #1;
    lamps = {MR, MY, MG, SR, SY, SG};
    checks++;
    if (phase !== ep) begin
      errors++;
      $display("FAIL %s phase: got %0d expected %0d", nm, phase, ep);
    end
    checks++;
    if (lamps !== exp_lamps(ep)) begin
      errors++;
      $display("FAIL %s lamps: got %b expected %b", nm, lamps, exp_lamps(ep));
    end
    ok = ($countones({MR, MY, MG}) == 1) && ($countones({SR, SY, SG}) == 1) &&
         !((MG | MY) && (SG | SY));
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s exclusive: lamps %b not one-per-road/conflict-free", nm, lamps);
    end
`ifdef PED_WALK_EN
    checks++;
    if (walk !== (ep == 3'd4)) begin
      errors++;
      $display("FAIL %s walk: got %b expected %b", nm, walk, (ep == 3'd4));
    end
`endif
  endtask

  typedef struct {
    logic r, t, s;
    logic [2:0] ph;
  } vec_t;

  vec_t tbl[29];

  initial begin
    rst = 1'b0; tick = 1'b0; side_req = 1'b0;
`ifdef PED_WALK_EN
    ped_req = 1'b0;
`endif
    // reset 3 cycles, release, first cycle with side_req pulse on MG cycle 1,
    // then side_req held high across the next cycle
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3'd1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 3'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'd1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'd2};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 3'd3};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 3'd4};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd4};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd4};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 3'd5};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 3'd5};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 3'd6};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 3'd1};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 3'd1};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 3'd1};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 3'd1};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 3'd2};
    tbl[22] = '{1'b1, 1'b1, 1'b1, 3'd2};
    tbl[23] = '{1'b1, 1'b1, 1'b1, 3'd3};
    tbl[24] = '{1'b1, 1'b1, 1'b1, 3'd4};
    tbl[25] = '{1'b1, 1'b1, 1'b1, 3'd4};
    tbl[26] = '{1'b1, 1'b1, 1'b1, 3'd4};
    tbl[27] = '{1'b1, 1'b1, 1'b1, 3'd5};
    tbl[28] = '{1'b1, 1'b1, 1'b1, 3'd5};

    for (int i = 0; i < 29; i++)
      step(tbl[i].r, tbl[i].t, tbl[i].s, 1'b0, tbl[i].ph, $sformatf("vec%0d", i));

    // tick low in SIDE_YELLOW: frozen, demand keeps latching
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, "freeze");

    // demand latched in SIDE_YELLOW: next main green is exactly 4 cycles
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, "relatch_c2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "relatch_mg0");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "relatch_mg");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "relatch_my");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "relatch_my1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, "relatch_c1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, "relatch_sg");

    // reset in the middle of SIDE_GREEN
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "midreset");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "post_reset_mg");

    // no demand: rest in MAIN_GREEN
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "rest");

    // demand after min green elapsed leaves on the next tick
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, "late_req");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "late_leave");

    // run back to main green
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "back_my");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, "back_c1");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, "back_sg");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, "back_sy");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, "back_sy1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, "back_c2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "back_mg");

`ifdef PED_WALK_EN
    // pedestrian pulse: walk exactly during side green
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, "ped_pulse");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "ped_mg1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, "ped_mg2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "ped_my");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "ped_my1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, "ped_c1");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, "ped_sg");
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd5, "ped_sy");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Timed, demand-driven phase sequencer for a main/side road intersection. It replaces the free-running one-state-per-clock light cycler with dwell timers, a latched side-road demand and all-red clearance intervals. It sits between the lamp drivers and the system tick generator and drives the six lamp outputs directly.

## Interface
- MIN_GREEN, 8: minimum main-green dwell in ticks (≥1)
- SIDE_GREEN, 6: side-green dwell in ticks (≥1)
- YELLOW, 3: yellow dwell in ticks, both roads (≥1)
- ALL_RED, 1: all-red clearance dwell in ticks (≥1)
- CNT_W, 6: dwell counter width; every dwell parameter must be ≤ 2^CNT_W
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- tick  in  1  one-cycle timebase strobe; all dwell timers advance only on tick
- side_req  in  1  side-road vehicle sensor, level, synchronous to clk
- ped_req  in  1  pedestrian push-button pulse (PED_WALK_EN only)
- MR, MY, MG  out  1 each  main-road red/yellow/green lamps, registered
- SR, SY, SG  out  1 each  side-road red/yellow/green lamps, registered
- walk  out  1  pedestrian walk lamp, registered (PED_WALK_EN only)
- phase  out  3  current state code, registered

## Operation
- States and codes: INIT_RED 0, MAIN_GREEN 1, MAIN_YELLOW 2, CLEAR_1 3, SIDE_GREEN 4, SIDE_YELLOW 5, CLEAR_2 6. Code 7 is illegal and recovers to INIT_RED on the next cycle.
- Lamps per state (M/S): INIT_RED R/R, MAIN_GREEN G/R, MAIN_YELLOW Y/R, CLEAR_1 R/R, SIDE_GREEN R/G, SIDE_YELLOW R/Y, CLEAR_2 R/R.
- Exactly one lamp per road is on in every cycle. Main is never G or Y while side is G or Y.
- Dwell counter cnt: cleared to 0 on every state entry; increments on tick (saturating).
- "Dwell D expires" means: tick=1 and cnt==D-1 in the same cycle.
- INIT_RED → MAIN_GREEN when ALL_RED expires.
- MAIN_GREEN:
  - Rests indefinitely while demand=0.
  - With demand=1, → MAIN_YELLOW on the first tick where cnt ≥ MIN_GREEN-1.
  - A demand arriving after min green has elapsed leaves on the next tick.
- MAIN_YELLOW → CLEAR_1 when YELLOW expires.
- CLEAR_1 → SIDE_GREEN when ALL_RED expires.
- SIDE_GREEN → SIDE_YELLOW when SIDE_GREEN expires.
- SIDE_YELLOW → CLEAR_2 when YELLOW expires.
- CLEAR_2 → MAIN_GREEN when ALL_RED expires.
- demand latch:
  - Set by side_req=1 in any state except SIDE_GREEN.
  - Cleared on the transition into SIDE_GREEN; the clear wins over a simultaneous set.
  - side_req during SIDE_GREEN is ignored.
- tick=0 freezes cnt and state. demand still latches while frozen.

## Timing
- Reset (rst=0 at an edge): state=INIT_RED, cnt=0, demand=0, MR=1, SR=1, MY=MG=SY=SG=0, walk=0, phase=0.
- Reset applied mid-operation (any state) has the same effect in one cycle.
- Lamps and phase are registered decodes of the next state. They change on the same edge as the state register, with no extra latency.
- With tick=1 every cycle, each state lasts exactly its dwell in clocks. MAIN_GREEN is the exception: it lasts max(MIN_GREEN, cycles until demand).
- side_req latency: sampled at edge N sets demand at N. It can cause a transition no earlier than edge N+1.

## Configuration
- PED_WALK_EN defined:
  - ped_req and walk ports exist.
  - A ped_req pulse sets demand under the same rules as side_req; ped_req during SIDE_GREEN is ignored.
  - walk=1 exactly while in SIDE_GREEN.
- PED_WALK_EN undefined: ped_req and walk ports are absent; behaviour is otherwise identical.

## Structure
- Package traffic_pkg holds the phase_t enum (codes above) and the lamp-vector constants per phase.
- One sub-module, dwell_timer: holds cnt, takes a clear/tick input and a dwell value, and outputs expire and min_elapsed.

## Test plan
- Reset: hold rst=0 for 3 cycles, then release → MR=SR=1, all other lamps 0, phase=0. After ALL_RED=1 tick, MAIN_GREEN: MG=1, SR=1.
- No demand, tick every cycle, 100 cycles → remains in MAIN_GREEN (phase=1) throughout.
- MIN_GREEN=4, YELLOW=2, ALL_RED=1, SIDE_GREEN=3, side_req pulse on MAIN_GREEN cycle 1 → MG held 4 cycles, MY 2, all-red 1, SG 3, SY 2, all-red 1, then MG. The lamp-exclusivity assertion holds every cycle.
- side_req held high throughout the cycle above → demand re-latches after SIDE_GREEN. The next main green lasts exactly 4 cycles before yellow.
- tick low for 10 cycles in SIDE_YELLOW → no state or lamp change. With rst=0 mid-SIDE_GREEN → next cycle INIT_RED, all-red lamps.
- PED_WALK_EN: ped_req pulse in MAIN_GREEN → walk=1 exactly for the SIDE_GREEN cycles. Without the macro, the build has no walk port.
